ras_return_checker: RTL and testbench

- Back-end counterpart to the front-end return address stack (RAS).
- Records each predicted return target and the RAS pointer snapshot taken at prediction time in an in-order FIFO.
- Compares each prediction, in order, against the resolved return target from execute.
- On mismatch: redirects fetch, emits a RAS pointer-restore command, and holds off new predictions for a fixed recovery window.

---
 rtl/ras_return_checker.sv | 101 ++++++++++
 tb/tb_ras_return_checker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ras_return_checker.sv
// ras_return_checker: in-order check of RAS return predictions with redirect/restore; RAS_CHECK_STATS_EN adds hit/miss counters
module ras_return_checker #(
    parameter int ENTRIES_P     = 8,
    parameter int WIDTH_P       = 32,
    parameter int PTR_W_P       = 3,
    parameter int HOLD_CYCLES_P = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               pred_v_i,
    input  logic [WIDTH_P-1:0] pred_addr_i,
    input  logic [PTR_W_P-1:0] pred_ptr_i,
    output logic               pred_ready_o,
    input  logic               resolve_v_i,
    input  logic [WIDTH_P-1:0] resolve_addr_i,
    output logic               redirect_v_o,
    output logic [WIDTH_P-1:0] redirect_addr_o,
    output logic               restore_v_o,
    output logic [PTR_W_P-1:0] restore_ptr_o,
    output logic               underflow_o
`ifdef RAS_CHECK_STATS_EN
    ,
    output logic [31:0]        hit_count_o,
    output logic [31:0]        miss_count_o
`endif
);
    localparam int IDX_W  = $clog2(ENTRIES_P);
    localparam int HOLD_W = $clog2(HOLD_CYCLES_P + 1);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] REDIRECT = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;

    logic [1:0]         state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [IDX_W:0]     wr_ptr, rd_ptr;
    logic [WIDTH_P-1:0] addr_mem [ENTRIES_P];
    logic [PTR_W_P-1:0] ptr_mem  [ENTRIES_P];
    logic               empty, full, run, enq, deq, miss;

    always_comb begin
        run          = state == RUN;
        empty        = wr_ptr == rd_ptr;
        full         = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
        pred_ready_o = !full && run;
        enq          = pred_v_i && pred_ready_o;
        deq          = resolve_v_i && run && !empty;
        miss         = deq && (resolve_addr_i != addr_mem[rd_ptr[IDX_W-1:0]]);
        redirect_v_o = state == REDIRECT;
        restore_v_o  = state == REDIRECT;
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_mem[wr_ptr[IDX_W-1:0]] <= pred_addr_i;
            ptr_mem[wr_ptr[IDX_W-1:0]]  <= pred_ptr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state           <= RUN;
            hold_cnt        <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            redirect_addr_o <= '0;
            restore_ptr_o   <= '0;
            underflow_o     <= 1'b0;
        end else begin
            // a mispredict flushes everything younger, including a same-cycle enqueue
            if (enq && !miss)
                wr_ptr <= wr_ptr + 1'b1;
            if (miss) begin
                rd_ptr          <= wr_ptr;
                redirect_addr_o <= resolve_addr_i;
                restore_ptr_o   <= ptr_mem[rd_ptr[IDX_W-1:0]];
            end else if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            if (resolve_v_i && run && empty)
                underflow_o <= 1'b1;
            state    <= miss ? REDIRECT :
                        (state == REDIRECT) ? HOLD :
                        (state == HOLD && hold_cnt == HOLD_W'(1)) ? RUN : state;
            hold_cnt <= (state == REDIRECT) ? HOLD_W'(HOLD_CYCLES_P) :
                        (state == HOLD) ? hold_cnt - 1'b1 : hold_cnt;
        end
    end

`ifdef RAS_CHECK_STATS_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else begin
            if (deq && !miss && !(&hit_count_o))
                hit_count_o <= hit_count_o + 1'b1;
            if (miss && !(&miss_count_o))
                miss_count_o <= miss_count_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ras_return_checker.sv
// tb_ras_return_checker: directed stimulus with a redirect scoreboard checked by a separate monitor
module tb_ras_return_checker;
    logic        clk_i = 1'b0;
    logic        reset_i, pred_v_i, resolve_v_i;
    logic [31:0] pred_addr_i, resolve_addr_i, redirect_addr_o;
    logic [2:0]  pred_ptr_i, restore_ptr_o;
    logic        pred_ready_o, redirect_v_o, restore_v_o, underflow_o;
`ifdef RAS_CHECK_STATS_EN
    logic [31:0] hit_count_o, miss_count_o;
`endif

    typedef struct {
        logic [31:0] a;
        logic [2:0]  p;
    } exp_t;
    exp_t q[$];
    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    ras_return_checker dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .pred_v_i(pred_v_i), .pred_addr_i(pred_addr_i), .pred_ptr_i(pred_ptr_i),
        .pred_ready_o(pred_ready_o),
        .resolve_v_i(resolve_v_i), .resolve_addr_i(resolve_addr_i),
        .redirect_v_o(redirect_v_o), .redirect_addr_o(redirect_addr_o),
        .restore_v_o(restore_v_o), .restore_ptr_o(restore_ptr_o),
        .underflow_o(underflow_o)
`ifdef RAS_CHECK_STATS_EN
        , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
        else passed++;
    endtask

    task automatic drive(input logic pv, input logic [31:0] pa, input logic [2:0] pp,
                         input logic rv, input logic [31:0] ra);
        pred_v_i = pv; pred_addr_i = pa; pred_ptr_i = pp;
        resolve_v_i = rv; resolve_addr_i = ra;
        @(posedge clk_i);
        #1;
        pred_v_i = 1'b0;
        resolve_v_i = 1'b0;
    endtask

    task automatic step();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    endtask

    task automatic mispredict(input logic [31:0] ra, input logic [2:0] eptr,
                              input logic pv, input logic [31:0] pa);
        exp_t e;
        e.a = ra;
        e.p = eptr;
        q.push_back(e);
        drive(pv, pa, 3'd1, 1'b1, ra);
    endtask

    always @(negedge clk_i) begin
        if (reset_i === 1'b0 && (redirect_v_o === 1'b1 || restore_v_o === 1'b1)) begin
            chk("redirect_v", {31'b0, redirect_v_o}, 32'd1);
            chk("restore_v", {31'b0, restore_v_o}, 32'd1);
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_redirect: got addr %h expected no redirect", redirect_addr_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("redirect_addr", redirect_addr_o, e.a);
                chk("restore_ptr", {29'b0, restore_ptr_o}, {29'b0, e.p});
            end
        end
    end

    initial begin
        reset_i = 1'b1; pred_v_i = 1'b0; resolve_v_i = 1'b0;
        pred_addr_i = '0; resolve_addr_i = '0; pred_ptr_i = '0;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        chk("rst_ready", {31'b0, pred_ready_o}, 32'd1);
        chk("rst_redirect_v", {31'b0, redirect_v_o}, 32'd0);
        chk("rst_restore_v", {31'b0, restore_v_o}, 32'd0);
        chk("rst_redirect_addr", redirect_addr_o, 32'h0);
        chk("rst_restore_ptr", {29'b0, restore_ptr_o}, 32'h0);
        chk("rst_underflow", {31'b0, underflow_o}, 32'd0);

        drive(1'b1, 32'h100, 3'd3, 1'b0, 32'h0);
        chk("t1_ready_a", {31'b0, pred_ready_o}, 32'd1);
        drive(1'b1, 32'h200, 3'd2, 1'b0, 32'h0);
        chk("t1_ready_b", {31'b0, pred_ready_o}, 32'd1);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 32'h100);
        chk("t1_ready_r1", {31'b0, pred_ready_o}, 32'd1);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 32'h200);
        chk("t1_ready_r2", {31'b0, pred_ready_o}, 32'd1);

        drive(1'b1, 32'h100, 3'd5, 1'b0, 32'h0);
        drive(1'b1, 32'h300, 3'd4, 1'b0, 32'h0);
        mispredict(32'h104, 3'd5, 1'b0, 32'h0);
        chk("t2_pulse_n1", {31'b0, redirect_v_o}, 32'd1);
        chk("t2_ready_n1", {31'b0, pred_ready_o}, 32'd0);
        step();
        chk("t2_pulse_n2", {31'b0, redirect_v_o}, 32'd0);
        chk("t2_ready_n2", {31'b0, pred_ready_o}, 32'd0);
        step();
        chk("t2_ready_n3", {31'b0, pred_ready_o}, 32'd0);
        step();
        chk("t2_ready_n4", {31'b0, pred_ready_o}, 32'd1);
        chk("t2_addr_hold", redirect_addr_o, 32'h104);
        chk("t2_ptr_hold", {29'b0, restore_ptr_o}, 32'd5);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h1000 + 32'(i * 4), 3'(i), 1'b0, 32'h0);
            chk($sformatf("t3_ready_fill%0d", i), {31'b0, pred_ready_o}, (i < 7) ? 32'd1 : 32'd0);
        end
        drive(1'b1, 32'h0bad, 3'd0, 1'b1, 32'h1000);
        chk("t3_ready_after_deq", {31'b0, pred_ready_o}, 32'd1);
        drive(1'b1, 32'h2000, 3'd7, 1'b0, 32'h0);
        chk("t3_full_again", {31'b0, pred_ready_o}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 32'h0, 3'd0, 1'b1, 32'h1000 + 32'(i * 4));
            chk($sformatf("t3_ready_drain%0d", i), {31'b0, pred_ready_o}, 32'd1);
        end
        drive(1'b0, 32'h0, 3'd0, 1'b1, 32'h2000);
        chk("t3_ready_empty", {31'b0, pred_ready_o}, 32'd1);

        chk("t4_underflow_pre", {31'b0, underflow_o}, 32'd0);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 32'h42);
        chk("t4_underflow_set", {31'b0, underflow_o}, 32'd1);
        repeat (3) step();
        chk("t4_underflow_sticky", {31'b0, underflow_o}, 32'd1);

        drive(1'b1, 32'h700, 3'd6, 1'b0, 32'h0);
        mispredict(32'h710, 3'd6, 1'b1, 32'h500);
        repeat (3) step();
        chk("t5_ready_after_hold", {31'b0, pred_ready_o}, 32'd1);
        drive(1'b1, 32'h600, 3'd2, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 32'h600);
        step();
        chk("t5_no_redirect", {31'b0, redirect_v_o}, 32'd0);
        chk("t5_addr_hold", redirect_addr_o, 32'h710);

        drive(1'b1, 32'h800, 3'd3, 1'b0, 32'h0);
        mispredict(32'h900, 3'd3, 1'b0, 32'h0);
        step();
        chk("t6_in_hold", {31'b0, pred_ready_o}, 32'd0);
`ifdef RAS_CHECK_STATS_EN
        chk("t6_hits", hit_count_o, 32'd12);
        chk("t6_misses", miss_count_o, 32'd3);
`endif
        reset_i = 1'b1;
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        chk("t6_ready", {31'b0, pred_ready_o}, 32'd1);
        chk("t6_redirect_v", {31'b0, redirect_v_o}, 32'd0);
        chk("t6_restore_v", {31'b0, restore_v_o}, 32'd0);
        chk("t6_redirect_addr", redirect_addr_o, 32'h0);
        chk("t6_restore_ptr", {29'b0, restore_ptr_o}, 32'h0);
        chk("t6_underflow", {31'b0, underflow_o}, 32'd0);
`ifdef RAS_CHECK_STATS_EN
        chk("t6_hits_rst", hit_count_o, 32'd0);
        chk("t6_misses_rst", miss_count_o, 32'd0);
`endif
        step();
        chk("t6_ready_stays", {31'b0, pred_ready_o}, 32'd1);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 32'h55);
        chk("t6_fifo_empty", {31'b0, underflow_o}, 32'd1);
        repeat (2) step();

        chk("pending_redirects", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
